// File: rtl/hazard_pkg.sv
// Shared types and constants for the pipeline hazard controller.
package hazard_pkg;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    EX_BUSY  = 2'd1,
    MEM_WAIT = 2'd2
  } hc_state_t;

  localparam logic [4:0] XZR = 5'd31;

endpackage

// File: rtl/load_use_detect.sv
// Combinational load-use compare between the ID/EX load and the IF/ID reader.
module load_use_detect
  import hazard_pkg::*;
(
  input  logic [4:0] ifid_rn_i,
  input  logic [4:0] ifid_rm_i,
  input  logic       ifid_uses_rn_i,
  input  logic       ifid_uses_rm_i,
  input  logic       idex_mem_read_i,
  input  logic [4:0] idex_rd_i,
  output logic       load_use_o
);

  // XZR reads as zero, so a load targeting it never feeds a dependent op.
  assign load_use_o = idex_mem_read_i && (idex_rd_i != XZR) &&
                      ((ifid_uses_rn_i && (ifid_rn_i == idex_rd_i)) ||
                       (ifid_uses_rm_i && (ifid_rm_i == idex_rd_i)));

endmodule

// File: rtl/hazard_control_unit.sv
// Pipeline sequencing controller: load-use bubbles, branch flush,
// multi-cycle EX freeze, data-memory wait freeze and a stall-cycle counter.
module hazard_control_unit
  import hazard_pkg::*;
#(
  parameter int unsigned MUL_LATENCY = 4,
  parameter int unsigned CNT_W       = 32
) (
  input  logic             clk_i,
  input  logic             reset_i,
  input  logic [4:0]       ifid_rn_i,
  input  logic [4:0]       ifid_rm_i,
  input  logic             ifid_uses_rn_i,
  input  logic             ifid_uses_rm_i,
  input  logic             idex_mem_read_i,
  input  logic [4:0]       idex_rd_i,
  input  logic             ex_multi_start_i,
  input  logic             br_taken_i,
  input  logic             dmem_req_i,
  input  logic             dmem_ready_i,
  output logic             pc_we_o,
  output logic             ifid_we_o,
  output logic             ifid_flush_o,
  output logic             idex_we_o,
  output logic             idex_bubble_o,
  output logic             exmem_we_o,
  output logic             exmem_bubble_o,
  output logic             memwb_bubble_o,
  output logic             busy_o,
  output logic [CNT_W-1:0] stall_cycles_o
);

  localparam int unsigned CW = $clog2(MUL_LATENCY);

  hc_state_t        state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [CNT_W-1:0] stall_q, stall_d;
  logic             load_use;
  logic             mem_freeze;

  load_use_detect u_load_use (
    .ifid_rn_i       (ifid_rn_i),
    .ifid_rm_i       (ifid_rm_i),
    .ifid_uses_rn_i  (ifid_uses_rn_i),
    .ifid_uses_rm_i  (ifid_uses_rm_i),
    .idex_mem_read_i (idex_mem_read_i),
    .idex_rd_i       (idex_rd_i),
    .load_use_o      (load_use)
  );

  // Once in MEM_WAIT only dmem_ready releases the freeze.
  assign mem_freeze = ((state_q == RUN) && dmem_req_i && !dmem_ready_i) ||
                      ((state_q == MEM_WAIT) && !dmem_ready_i);

  always_comb begin
    state_d        = state_q;
    cnt_d          = cnt_q;
    pc_we_o        = 1'b1;
    ifid_we_o      = 1'b1;
    ifid_flush_o   = 1'b0;
    idex_we_o      = 1'b1;
    idex_bubble_o  = 1'b0;
    exmem_we_o     = 1'b1;
    exmem_bubble_o = 1'b0;
    memwb_bubble_o = 1'b0;
    if (state_q == EX_BUSY) begin
      pc_we_o        = 1'b0;
      ifid_we_o      = 1'b0;
      idex_we_o      = 1'b0;
      exmem_bubble_o = 1'b1;
      cnt_d          = cnt_q - 1'b1;
      if (cnt_q == CW'(1)) state_d = RUN;
    end else if (mem_freeze) begin
      pc_we_o        = 1'b0;
      ifid_we_o      = 1'b0;
      idex_we_o      = 1'b0;
      exmem_we_o     = 1'b0;
      memwb_bubble_o = 1'b1;
      state_d        = MEM_WAIT;
    end else begin
      state_d = RUN;
      if (ex_multi_start_i) begin
        pc_we_o        = 1'b0;
        ifid_we_o      = 1'b0;
        idex_we_o      = 1'b0;
        exmem_bubble_o = 1'b1;
        cnt_d          = CW'(MUL_LATENCY - 2);
        if (MUL_LATENCY > 2) state_d = EX_BUSY;
      end else if (br_taken_i) begin
        ifid_flush_o  = 1'b1;
        idex_bubble_o = 1'b1;
      end else if (load_use) begin
        pc_we_o       = 1'b0;
        ifid_we_o     = 1'b0;
        idex_bubble_o = 1'b1;
      end
    end
  end

  assign stall_d = pc_we_o ? stall_q : stall_q + CNT_W'(1);

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q <= RUN;
      cnt_q   <= '0;
      stall_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      stall_q <= stall_d;
    end
  end

  assign busy_o         = (state_q != RUN);
  assign stall_cycles_o = stall_q;

endmodule

// File: doc/hazard_control_unit.md
# hazard_control_unit

Pipeline sequencing controller for the 5-stage ARM datapath. Sits beside the operand forwarding logic and decides, every cycle, which pipeline registers advance, hold, flush or take a bubble. Handles the hazards forwarding cannot resolve: load-use, taken-branch flush, multi-cycle EX operations and data-memory wait states. Also keeps a stall-cycle performance counter.

## Interface
- MUL_LATENCY, 4, total EX occupancy in cycles of a multi-cycle op (≥2)
- CNT_W, 32, width of stall_cycles

- clk  in  1  clock; all state updates on rising edge
- reset  in  1  synchronous, active-high
- ifid_rn  in  5  Rn field of instruction in IF/ID
- ifid_rm  in  5  Rm field of instruction in IF/ID
- ifid_uses_rn  in  1  IF/ID instruction reads Rn
- ifid_uses_rm  in  1  IF/ID instruction reads Rm
- idex_mem_read  in  1  ID/EX instruction is a load
- idex_rd  in  5  destination of ID/EX instruction
- ex_multi_start  in  1  multi-cycle op entering EX this cycle
- br_taken  in  1  branch resolved taken this cycle
- dmem_req  in  1  MEM stage accessing data memory
- dmem_ready  in  1  data memory completes access this cycle
- pc_we  out  1  PC register enable
- ifid_we  out  1  IF/ID enable
- ifid_flush  out  1  IF/ID loads NOP
- idex_we  out  1  ID/EX enable
- idex_bubble  out  1  ID/EX loads NOP
- exmem_we  out  1  EX/MEM enable
- exmem_bubble  out  1  EX/MEM loads NOP
- memwb_bubble  out  1  MEM/WB loads NOP
- busy  out  1  state ≠ RUN
- stall_cycles  out  CNT_W  count of cycles with pc_we=0

## Operation
- States: RUN, EX_BUSY, MEM_WAIT. Register 31 (XZR) never creates a hazard.
- Outputs combinational from state and inputs. Default: all *_we=1, all flush/bubble=0.
- load_use = idex_mem_read & idex_rd≠31 & ((ifid_uses_rn & ifid_rn==idex_rd) | (ifid_uses_rm & ifid_rm==idex_rd)).
- RUN priority, highest first:
  - dmem_req & !dmem_ready: pc/ifid/idex/exmem_we=0, memwb_bubble=1; next MEM_WAIT.
  - ex_multi_start: pc/ifid/idex_we=0, exmem_bubble=1; cnt←MUL_LATENCY-2; next = EX_BUSY, or RUN if MUL_LATENCY==2.
  - br_taken: ifid_flush=1, idex_flush via idex_bubble=1, pc_we=1; stay RUN.
  - load_use: pc_we=0, ifid_we=0, idex_bubble=1; stay RUN. Exactly one bubble per load.
- EX_BUSY: pc/ifid/idex_we=0, exmem_bubble=1; cnt decrements; cnt==1 → RUN. br_taken and load_use ignored.
- MEM_WAIT: same freeze as RUN mem-stall entry while !dmem_ready. With dmem_ready=1: evaluate RUN rules, memory condition false; next state per those rules.
- stall_cycles increments each cycle pc_we=0; wraps at 2^CNT_W.
- reset: state←RUN, cnt←0, stall_cycles←0; reset dominates all inputs.

## Timing
- Zero-cycle decision latency: outputs valid in the same cycle as the inputs.
- Multi-cycle op: exactly MUL_LATENCY-1 freeze cycles, including the start cycle. Result is captured into EX/MEM on the next cycle.
- Memory wait: freeze lasts for every cycle dmem_ready=0. 0 extra cycles if ready on the first request cycle.
- Simultaneous branch + load_use: the branch wins. The dependent instruction is flushed, so no bubble.
- Simultaneous mem-stall + anything: the memory freeze wins. Other conditions are re-evaluated on the release cycle.
- Reset asserted mid-EX_BUSY or mid-MEM_WAIT: next cycle in RUN with default outputs.
- After reset: pc_we=ifid_we=idex_we=exmem_we=1, all flush/bubble=0, busy=0, stall_cycles=0.

## Structure
- Shared package hazard_pkg:
  - state enum hc_state_t {RUN, EX_BUSY, MEM_WAIT}
  - constant XZR=5'd31
- Sub-module load_use_detect: pure combinational load_use compare, reusable by the debug trace logic.
- Top module: FSM, latency counter ($clog2(MUL_LATENCY) bits), perf counter.

## Test plan
- Load-use: LDUR X2 in ID/EX, ADD reading X2 (Rn) in IF/ID → one cycle pc_we=0, ifid_we=0, idex_bubble=1; stall_cycles=1. Repeat with idex_rd=31 → no stall.
- Multi-cycle op, MUL_LATENCY=4: ex_multi_start for one cycle → pc_we=0 for exactly 3 cycles, busy high for 2, exmem_bubble high for 3; stall_cycles=3.
- Memory wait: dmem_req=1, dmem_ready low for 5 cycles → full freeze 5 cycles, memwb_bubble=1; release cycle shows all enables 1.
- Priority: br_taken and load_use asserted together → ifid_flush=1, idex_bubble=1, pc_we=1, no stall count.
- Reset mid-EX_BUSY (cycle 2 of 3) → next cycle busy=0, enables 1, stall_cycles=0.
- Counter wrap with CNT_W=4: 17 stall cycles → stall_cycles=1.
